axis_relay_n: RTL and testbench

AXIS_RELAY_N -- requirements
Module: axis_relay_n

---
 rtl/axis_relay_n.sv | 72 +++++++
 tb/tb_axis_relay_n.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/axis_relay_n.sv
// axis_relay_n: C_DEPTH-slot AXI-Stream video relay with registered upstream ready.
// Define AXIS_RELAY_N_SOF_SYNC_EN to drop beats until the first start-of-frame.
module axis_relay_n #(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_DEPTH       = 4,
  parameter int C_TEST        = 0
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             s_axis_tvalid,
  input  logic [C_PIXEL_WIDTH-1:0]         s_axis_tdata,
  input  logic                             s_axis_tuser,
  input  logic                             s_axis_tlast,
  output logic                             s_axis_tready,
  output logic                             m_axis_tvalid,
  output logic [C_PIXEL_WIDTH-1:0]         m_axis_tdata,
  output logic                             m_axis_tuser,
  output logic                             m_axis_tlast,
  input  logic                             m_axis_tready,
  output logic [$clog2(C_DEPTH+1)-1:0]     level
);
  localparam int AW = $clog2(C_DEPTH);
  localparam int LW = $clog2(C_DEPTH+1);
  localparam int W  = C_PIXEL_WIDTH + 2;
  logic [W-1:0]  mem_q [C_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic          rdy_q, rdy_d;
  logic          accept, pop, store;
  logic          unused_ok;
  assign unused_ok = (C_TEST != 0);
  assign accept = s_axis_tvalid & rdy_q;
  assign pop    = (level_q != '0) & m_axis_tready;
`ifdef AXIS_RELAY_N_SOF_SYNC_EN
  typedef enum logic {WAIT_SOF, PASS} state_t;
  state_t state_q, state_d;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state_q <= WAIT_SOF;
    else         state_q <= state_d;
  always_comb
    state_d = (state_q == WAIT_SOF && accept && s_axis_tuser) ? PASS : state_q;
  // Beats before the first SOF are consumed but never stored.
  always_comb
    store = accept & ((state_q == PASS) | s_axis_tuser);
`else
  always_comb store = accept;
`endif
  always_comb begin
    level_d = level_q + LW'(store) - LW'(pop);
    wr_d    = store ? wr_q + AW'(1) : wr_q;
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    rdy_d   = level_d < LW'(C_DEPTH);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      rdy_q   <= rdy_d;
    end
  always_ff @(posedge clk)
    if (store) mem_q[wr_q] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = mem_q[rd_q];
  assign m_axis_tvalid = (level_q != '0);
  assign s_axis_tready = rdy_q;
  assign level         = level_q;
endmodule

// File: tb/tb_axis_relay_n.sv
// tb_axis_relay_n: directed checks of axis_relay_n (C_DEPTH=4, 8-bit pixels).
module tb_axis_relay_n;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       s_valid = 1'b0, s_user = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_ready, m_valid, m_user, m_last;
  logic [7:0] m_data;
  logic [2:0] level;
  logic [9:0] q [$];
  int checks = 0;
  int errors = 0;
  int max_level;
  axis_relay_n #(.C_PIXEL_WIDTH(8), .C_DEPTH(4), .C_TEST(0)) dut (
    .clk(clk), .resetn(resetn),
    .s_axis_tvalid(s_valid), .s_axis_tdata(s_data), .s_axis_tuser(s_user),
    .s_axis_tlast(s_last), .s_axis_tready(s_ready),
    .m_axis_tvalid(m_valid), .m_axis_tdata(m_data), .m_axis_tuser(m_user),
    .m_axis_tlast(m_last), .m_axis_tready(m_ready), .level(level)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (m_valid && m_ready) q.push_back({m_user, m_last, m_data});
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [7:0] d, input logic u, input logic l);
    s_valid = 1'b1; s_data = d; s_user = u; s_last = l;
    step();
    s_valid = 1'b0; s_user = 1'b0; s_last = 1'b0;
  endtask
  initial begin
    #3;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_level", level, 0);
    step(); step();
    resetn = 1'b1;
    step();
    chk("ready_after_rst", s_ready, 1);
    // start-of-frame behaviour
    m_ready = 1'b1;
    push(8'hA0, 0, 0);
    push(8'hA1, 0, 0);
    push(8'hB0, 1, 0);
    push(8'hB1, 0, 0);
    step(); step();
`ifdef AXIS_RELAY_N_SOF_SYNC_EN
    chk("sof_count", q.size(), 2);
    if (q.size() == 2) begin
      chk("sof_beat0", q[0], 10'h2B0);
      chk("sof_beat1", q[1], 10'h0B1);
    end
`else
    chk("sof_count", q.size(), 4);
    if (q.size() == 4) begin
      chk("sof_beat0", q[0], 10'h0A0);
      chk("sof_beat1", q[1], 10'h0A1);
      chk("sof_beat2", q[2], 10'h2B0);
      chk("sof_beat3", q[3], 10'h0B1);
    end
`endif
    q.delete();
    // fill to full with downstream stalled
    m_ready = 1'b0;
    push(8'h11, 0, 0);
    chk("first_latency_valid", m_valid, 1);
    chk("first_latency_data", m_data, 8'h11);
    push(8'h22, 0, 0);
    push(8'h33, 0, 0);
    push(8'h44, 0, 1);
    chk("full_level", level, 4);
    chk("full_s_ready", s_ready, 0);
    chk("full_head", m_data, 8'h11);
    s_valid = 1'b1; s_data = 8'h99;
    step();
    s_valid = 1'b0;
    chk("full_hold_data", m_data, 8'h11);
    chk("full_hold_level", level, 4);
    // single-cycle pop from full
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("pop_level", level, 3);
    chk("pop_s_ready", s_ready, 1);
    chk("pop_head", m_data, 8'h22);
    push(8'h55, 0, 0);
    chk("refill_level", level, 4);
    m_ready = 1'b1;
    repeat (6) step();
    chk("drain_valid", m_valid, 0);
    chk("drain_level", level, 0);
    chk("order_count", q.size(), 5);
    if (q.size() == 5) begin
      chk("order0", q[0], 10'h011);
      chk("order1", q[1], 10'h022);
      chk("order2", q[2], 10'h033);
      chk("order3", q[3], 10'h144);
      chk("order4", q[4], 10'h055);
    end
    q.delete();
    // streaming at full rate
    max_level = 0;
    s_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      s_data = 8'(i);
      s_last = (i % 16 == 15);
      step();
      if (int'(level) > max_level) max_level = int'(level);
    end
    s_valid = 1'b0; s_last = 1'b0;
    chk("stream_popped_inline", q.size(), 999);
    step();
    chk("stream_count", q.size(), 1000);
    chk("stream_max_level", max_level, 1);
    if (q.size() == 1000)
      for (int i = 0; i < 1000; i++)
        chk("stream_beat", q[i], {1'b0, (i % 16 == 15), 8'(i)});
    q.delete();
    // asynchronous reset mid-frame
    m_ready = 1'b0;
    push(8'h61, 0, 0);
    push(8'h62, 0, 0);
    push(8'h63, 0, 0);
    chk("pre_rst_level", level, 3);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_m_valid", m_valid, 0);
    chk("async_s_ready", s_ready, 0);
    chk("async_level", level, 0);
    m_ready = 1'b1;
    step();
    resetn = 1'b1;
    step();
    chk("post_rst_level", level, 0);
    chk("post_rst_m_valid", m_valid, 0);
    chk("post_rst_s_ready", s_ready, 1);
    step();
    chk("post_rst_no_output", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
